// File: rtl/div_pkg.sv
// Shared arithmetic-unit definitions.
// Holds the opcode encodings for the divider and multiplier, the divider
// FSM state type, and a helper that takes the magnitude of a two's-complement value.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_DIV  = 2'd0,
        DIV_DIVU = 2'd1,
        DIV_MOD  = 2'd2,
        DIV_MODU = 2'd3
    } div_opcode_t;

    typedef enum logic [1:0] {
        MUL_MUL    = 2'd0,
        MUL_MULH   = 2'd1,
        MUL_MULHSU = 2'd2,
        MUL_MULHU  = 2'd3
    } mul_opcode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    localparam logic [4:0] DIV_LAST_ITER = 5'd31;

    // Returns |x| when neg is set (x treated as negative), else x unchanged.
    // 0x80000000 maps to itself, which is its correct unsigned magnitude.
    function automatic logic [31:0] div_mag(input logic [31:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/div.sv
// Iterative 32-bit integer divider (restoring radix-2, one quotient bit per cycle).
//
// Ports:
//   clk        - clock, rising edge
//   resetn     - asynchronous active-low reset
//   valid      - request strobe, accepted when valid && ready
//   opcode     - DIV_DIV / DIV_DIVU / DIV_MOD / DIV_MODU, sampled on accept
//   src1       - dividend, sampled on accept
//   src2       - divisor, sampled on accept
//   flush      - abort any operation; returns to IDLE next cycle
//   ready      - high only while idle
//   out_valid  - result valid, held until out_ready
//   out_ready  - consumer accepts the result
//   result     - quotient (DIV/DIVU) or remainder (MOD/MODU)
//
// Build option: define DIV_ZERO_FAST_EN to complete divide-by-zero directly
// from IDLE to DONE (result one cycle after accept instead of 33).
module div
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  div_opcode_t opcode,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    div_state_t  state_q, state_d;
    logic [63:0] rem_q, rem_d;      // {partial remainder, quotient/dividend}
    logic [31:0] dvsr_q, dvsr_d;    // divisor magnitude
    logic [4:0]  cnt_q, cnt_d;
    logic        is_mod_q, is_mod_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;

    logic        op_signed;
    logic        s1_neg;
    logic        s2_neg;
    logic [63:0] shifted;
    logic [32:0] trial;

    always_comb begin
        op_signed = (opcode == DIV_DIV) || (opcode == DIV_MOD);
        s1_neg    = op_signed & src1[31];
        s2_neg    = op_signed & src2[31];
        shifted   = {rem_q[62:0], 1'b0};
        trial     = {1'b0, shifted[63:32]} - {1'b0, dvsr_q};
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        dvsr_d   = dvsr_q;
        cnt_d    = cnt_q;
        is_mod_d = is_mod_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;

        unique case (state_q)
            S_IDLE: begin
                if (valid) begin
                    state_d  = S_CALC;
                    rem_d    = {32'd0, div_mag(src1, s1_neg)};
                    dvsr_d   = div_mag(src2, s2_neg);
                    cnt_d    = DIV_LAST_ITER;
                    is_mod_d = (opcode == DIV_MOD) || (opcode == DIV_MODU);
                    // Divide-by-zero quotient must stay all-ones, so never negate it.
                    // The remainder |src1| negated back by sign(src1) yields src1 itself.
                    q_neg_d  = (s1_neg ^ s2_neg) && (src2 != 32'd0);
                    r_neg_d  = s1_neg;
`ifdef DIV_ZERO_FAST_EN
                    if (src2 == 32'd0) begin
                        // Same final registers the full iteration would produce.
                        state_d = S_DONE;
                        rem_d   = {div_mag(src1, s1_neg), 32'hFFFF_FFFF};
                        cnt_d   = '0;
                    end
`endif
                end
            end
            S_CALC: begin
                rem_d = trial[32] ? shifted : {trial[31:0], shifted[31:1], 1'b1};
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            is_mod_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            dvsr_q   <= dvsr_d;
            cnt_q    <= cnt_d;
            is_mod_q <= is_mod_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);

    // Sign fix-up applied to the final registers; result reads zero outside DONE.
    always_comb begin
        result = '0;
        if (out_valid) begin
            if (is_mod_q) begin
                result = r_neg_q ? (~rem_q[63:32] + 32'd1) : rem_q[63:32];
            end else begin
                result = q_neg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
            end
        end
    end

endmodule
